// File: rtl/gps_pkg.sv
// Shared state encoding and default timing constants for the GPS code scheduler.
package gps_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOCK,
        RELEASE,
        RUN,
        STOPPING,
        FAULT
    } gps_state_e;

    localparam int SLOW_DIV       = 10;
    localparam int CA_LEN         = 1023;
    localparam int EPOCHS_PER_BIT = 20;
    localparam int LOCK_SETTLE    = 16;

endpackage

// File: rtl/gps_chip_counter.sv
// Divider -> C/A chip -> epoch cascade; all strobes and indices are registered and
// describe the cycle they are visible in (en/clr refer to that upcoming cycle).
module gps_chip_counter #(
    parameter int SLOW_DIV       = gps_pkg::SLOW_DIV,
    parameter int CA_LEN         = gps_pkg::CA_LEN,
    parameter int EPOCHS_PER_BIT = gps_pkg::EPOCHS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic       ca_ce,
    output logic       ca_epoch,
    output logic       bit_epoch,
    output logic [9:0] chip_idx,
    output logic [4:0] epoch_idx
);
    import gps_pkg::*;

    localparam int DIV_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             act_q;
    logic [9:0]       chip_d;
    logic [4:0]       epoch_d;
    logic             ca_ce_d, ca_epoch_d, bit_epoch_d;

    always_comb begin
        div_d   = div_q;
        chip_d  = chip_idx;
        epoch_d = epoch_idx;
        if (clr) begin
            div_d   = '0;
            chip_d  = '0;
            epoch_d = '0;
        end else if (en && act_q) begin
            // The first enabled cycle keeps the cleared values so it counts as div 0.
            if (div_q == DIV_W'(SLOW_DIV - 1)) begin
                div_d  = '0;
                chip_d = (chip_idx == 10'(CA_LEN - 1)) ? '0 : chip_idx + 10'd1;
                if (chip_idx == 10'(CA_LEN - 1)) begin
                    epoch_d = (epoch_idx == 5'(EPOCHS_PER_BIT - 1)) ? '0 : epoch_idx + 5'd1;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
        ca_ce_d     = en && !clr && (div_d == DIV_W'(SLOW_DIV - 1));
        ca_epoch_d  = ca_ce_d && (chip_d == 10'(CA_LEN - 1));
        bit_epoch_d = ca_epoch_d && (epoch_d == 5'(EPOCHS_PER_BIT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            act_q     <= 1'b0;
            chip_idx  <= '0;
            epoch_idx <= '0;
            ca_ce     <= 1'b0;
            ca_epoch  <= 1'b0;
            bit_epoch <= 1'b0;
        end else begin
            div_q     <= div_d;
            act_q     <= en && !clr;
            chip_idx  <= chip_d;
            epoch_idx <= epoch_d;
            ca_ce     <= ca_ce_d;
            ca_epoch  <= ca_epoch_d;
            bit_epoch <= bit_epoch_d;
        end
    end

endmodule

// File: rtl/gps_code_sched.sv
// Lock-qualified start/stop sequencer for the P and C/A code generators; every output
// is a flop loaded from the next-state decode so it matches the state it reports.
module gps_code_sched #(
    parameter int SLOW_DIV       = gps_pkg::SLOW_DIV,
    parameter int CA_LEN         = gps_pkg::CA_LEN,
    parameter int EPOCHS_PER_BIT = gps_pkg::EPOCHS_PER_BIT,
    parameter int LOCK_SETTLE    = gps_pkg::LOCK_SETTLE
) (
    input  logic       gps_clk_fast,
    input  logic       gps_rst_n,
    input  logic       mmcm_locked,
    input  logic       start_req,
    input  logic       stop_req,
    output logic       start_ack,
    output logic       core_rst,
    output logic       p_ce,
    output logic       ca_ce,
    output logic       ca_epoch,
    output logic       bit_epoch,
    output logic [9:0] chip_idx,
    output logic [4:0] epoch_idx,
    output logic       running,
    output logic       lock_err
);
    import gps_pkg::*;

    localparam int SETTLE_W = $clog2(LOCK_SETTLE + 1);

    if (CA_LEN < 1 || CA_LEN > 1024 || EPOCHS_PER_BIT < 1 || EPOCHS_PER_BIT > 32 ||
        SLOW_DIV < 1 || LOCK_SETTLE < 1) begin : g_param_check
        $error("gps_code_sched: CA_LEN must be 1..1024, EPOCHS_PER_BIT 1..32");
    end

    gps_state_e          state_q, state_d;
    logic                lock_meta, lock_sync;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                active_d;

    always_ff @(posedge gps_clk_fast or negedge gps_rst_n) begin
        if (!gps_rst_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= mmcm_locked;
            lock_sync <= lock_meta;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        case (state_q)
            IDLE: if (start_req) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (!start_req) begin
                    state_d = IDLE;
                end else if (lock_sync) begin
                    if (settle_q == SETTLE_W'(LOCK_SETTLE - 1)) state_d = RELEASE;
                    else settle_d = settle_q + SETTLE_W'(1);
                end
            end
            RELEASE: state_d = lock_sync ? RUN : FAULT;
            // Lock loss outranks stop so a dying clock never keeps enabling generators.
            RUN: begin
                if (!lock_sync)    state_d = FAULT;
                else if (stop_req) state_d = STOPPING;
            end
            STOPPING: begin
                if (!lock_sync)    state_d = FAULT;
                else if (ca_epoch) state_d = IDLE;
            end
            FAULT: if (start_req) state_d = WAIT_LOCK;
            default: state_d = IDLE;
        endcase
    end

    assign active_d = (state_d == RUN) || (state_d == STOPPING);

    always_ff @(posedge gps_clk_fast or negedge gps_rst_n) begin
        if (!gps_rst_n) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            start_ack <= 1'b0;
            core_rst  <= 1'b1;
            p_ce      <= 1'b0;
            running   <= 1'b0;
            lock_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            start_ack <= (state_q == RELEASE) && (state_d == RUN);
            core_rst  <= state_d inside {IDLE, WAIT_LOCK, FAULT};
            p_ce      <= active_d;
            running   <= active_d;
            lock_err  <= (state_d == FAULT);
        end
    end

    gps_chip_counter #(
        .SLOW_DIV       (SLOW_DIV),
        .CA_LEN         (CA_LEN),
        .EPOCHS_PER_BIT (EPOCHS_PER_BIT)
    ) u_chip_counter (
        .clk       (gps_clk_fast),
        .rst_n     (gps_rst_n),
        .clr       (!active_d),
        .en        (active_d),
        .ca_ce     (ca_ce),
        .ca_epoch  (ca_epoch),
        .bit_epoch (bit_epoch),
        .chip_idx  (chip_idx),
        .epoch_idx (epoch_idx)
    );

endmodule

// File: tb/tb_gps_code_sched.sv
// Scoreboard bench for gps_code_sched: expected output vectors are derived from run-cycle
// arithmetic, queued when stimulus is applied and popped once the clock edge has produced them.
module tb_gps_code_sched;

    localparam int SLOW_DIV    = 10;
    localparam int CA_LEN      = 1023;
    localparam int EPB         = 3;
    localparam int LOCK_SETTLE = 16;
    localparam int EPOCH_CYC   = SLOW_DIV * CA_LEN;
    // Cycle 1 ends on the first edge that samples start_req; ack shows in cycle 20.
    localparam int ACK_CYCLE   = 2 + LOCK_SETTLE + 2;
    localparam int RUN_N       = EPB * EPOCH_CYC + 5;
    localparam int STOP_N      = 500 * SLOW_DIV + 1;
    localparam int LOSS_N      = 50;
    localparam int MID_N       = 2000;
    localparam int GLITCH_K    = 10 + 2;
    localparam int GLITCH_ACK  = GLITCH_K + 3 + LOCK_SETTLE + 1;

    logic       clk = 1'b0;
    logic       gps_rst_n = 1'b0;
    logic       mmcm_locked = 1'b0;
    logic       start_req = 1'b0;
    logic       stop_req = 1'b0;
    logic       start_ack, core_rst, p_ce, ca_ce, ca_epoch, bit_epoch, running, lock_err;
    logic [9:0] chip_idx;
    logic [4:0] epoch_idx;
    logic [22:0] obs, exp_v;
    logic [22:0] sb[$];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    gps_code_sched #(
        .SLOW_DIV       (SLOW_DIV),
        .CA_LEN         (CA_LEN),
        .EPOCHS_PER_BIT (EPB),
        .LOCK_SETTLE    (LOCK_SETTLE)
    ) dut (
        .gps_clk_fast (clk),
        .gps_rst_n    (gps_rst_n),
        .mmcm_locked  (mmcm_locked),
        .start_req    (start_req),
        .stop_req     (stop_req),
        .start_ack    (start_ack),
        .core_rst     (core_rst),
        .p_ce         (p_ce),
        .ca_ce        (ca_ce),
        .ca_epoch     (ca_epoch),
        .bit_epoch    (bit_epoch),
        .chip_idx     (chip_idx),
        .epoch_idx    (epoch_idx),
        .running      (running),
        .lock_err     (lock_err)
    );

    assign obs = {start_ack, core_rst, p_ce, ca_ce, ca_epoch, bit_epoch, running, lock_err,
                  chip_idx, epoch_idx};

    function automatic logic [22:0] mk(bit ack, bit rst, bit pce, bit ce, bit ep, bit be,
                                       bit run, bit le, int chip, int epoch);
        logic [9:0] c;
        logic [4:0] e;
        c = 10'(chip);
        e = 5'(epoch);
        return {ack, rst, pce, ce, ep, be, run, le, c, e};
    endfunction

    function automatic logic [22:0] vec_off(bit le);
        return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, le, 0, 0);
    endfunction

    function automatic logic [22:0] vec_release();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endfunction

    // n = 1 is the first RUN cycle.
    function automatic logic [22:0] vec_run(int n);
        int k, dv, chip, ep;
        bit ce, cae, be;
        k    = n - 1;
        dv   = k % SLOW_DIV;
        chip = (k / SLOW_DIV) % CA_LEN;
        ep   = (k / EPOCH_CYC) % EPB;
        ce   = (dv == SLOW_DIV - 1);
        cae  = ce && (chip == CA_LEN - 1);
        be   = cae && (ep == EPB - 1);
        return mk(n == 1, 1'b0, 1'b1, ce, cae, be, 1'b1, 1'b0, chip, ep);
    endfunction

    function automatic logic [22:0] vec_boot(int k);
        if (k == ACK_CYCLE - 1) return vec_run(1);
        if (k == ACK_CYCLE - 2) return vec_release();
        return vec_off(1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then bring the DUT to its first RUN cycle with lock steady and start held.
    task automatic boot();
        gps_rst_n = 1'b0;
        start_req = 1'b0;
        stop_req = 1'b0;
        mmcm_locked = 1'b1;
        tick();
        tick();
        start_req = 1'b1;
        gps_rst_n = 1'b1;
        repeat (ACK_CYCLE - 1) tick();
    endtask

    task automatic test_reset();
        gps_rst_n = 1'b0;
        mmcm_locked = 1'b1;
        start_req = 1'b1;
        stop_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(vec_off(1'b0));
            tick();
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset k=%0d got=%h want=%h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_startup_run();
        int ce_cnt, ep_cnt, bit_cnt;
        ce_cnt = 0;
        ep_cnt = 0;
        bit_cnt = 0;
        stop_req = 1'b0;
        start_req = 1'b1;
        mmcm_locked = 1'b1;
        gps_rst_n = 1'b1;
        for (int k = 1; k < ACK_CYCLE - 1; k++) begin
            sb.push_back(vec_boot(k));
            tick();
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL startup k=%0d got=%h want=%h", k, obs, exp_v);
            end
        end
        for (int n = 1; n <= RUN_N; n++) begin
            sb.push_back(vec_run(n));
            tick();
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL run n=%0d got=%h want=%h", n, obs, exp_v);
            end
            ce_cnt += int'(ca_ce);
            ep_cnt += int'(ca_epoch);
            bit_cnt += int'(bit_epoch);
            if (n == 1) start_req = 1'b0;
        end
        vectors += 3;
        if (ce_cnt !== RUN_N / SLOW_DIV) begin
            miscompares++;
            $display("FAIL ca_ce_count got=%0d want=%0d", ce_cnt, RUN_N / SLOW_DIV);
        end
        if (ep_cnt !== RUN_N / EPOCH_CYC) begin
            miscompares++;
            $display("FAIL ca_epoch_count got=%0d want=%0d", ep_cnt, RUN_N / EPOCH_CYC);
        end
        if (bit_cnt !== 1) begin
            miscompares++;
            $display("FAIL bit_epoch_count got=%0d want=1", bit_cnt);
        end
    endtask

    // Stop at chip 500 with start_req still high: strobes run out the epoch, then IDLE.
    task automatic test_stop();
        boot();
        for (int n = 2; n <= EPOCH_CYC + 3; n++) begin
            sb.push_back(n <= EPOCH_CYC ? vec_run(n) : vec_off(1'b0));
            tick();
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL stop n=%0d got=%h want=%h", n, obs, exp_v);
            end
            if (n == STOP_N) stop_req = 1'b1;
            if (n == EPOCH_CYC + 1) begin
                stop_req = 1'b0;
                start_req = 1'b0;
            end
        end
    endtask

    task automatic test_lock_loss();
        boot();
        start_req = 1'b0;
        for (int n = 2; n <= LOSS_N + 7; n++) begin
            sb.push_back(n <= LOSS_N + 2 ? vec_run(n) : vec_off(1'b1));
            tick();
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL lock_loss n=%0d got=%h want=%h", n, obs, exp_v);
            end
            if (n == LOSS_N) begin
                mmcm_locked = 1'b0;
                stop_req = 1'b1;
            end
        end
        stop_req = 1'b0;
        mmcm_locked = 1'b1;
        start_req = 1'b1;
        for (int k = 1; k < ACK_CYCLE + 4; k++) begin
            sb.push_back(k < ACK_CYCLE ? vec_boot(k) : vec_run(k - ACK_CYCLE + 2));
            tick();
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL fault_restart k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (k == ACK_CYCLE - 1) start_req = 1'b0;
        end
    endtask

    // One-cycle lock dropout at settle count 10: a full settle is needed after it.
    task automatic test_lock_glitch();
        gps_rst_n = 1'b0;
        stop_req = 1'b0;
        start_req = 1'b0;
        mmcm_locked = 1'b1;
        tick();
        start_req = 1'b1;
        gps_rst_n = 1'b1;
        for (int k = 1; k <= GLITCH_ACK; k++) begin
            if (k == GLITCH_ACK)          sb.push_back(vec_run(1));
            else if (k == GLITCH_ACK - 1) sb.push_back(vec_release());
            else                          sb.push_back(vec_off(1'b0));
            tick();
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL lock_glitch k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (k == GLITCH_K)     mmcm_locked = 1'b0;
            if (k == GLITCH_K + 1) mmcm_locked = 1'b1;
        end
        start_req = 1'b0;
    endtask

    task automatic test_reset_midrun();
        boot();
        start_req = 1'b0;
        for (int n = 2; n <= MID_N; n++) begin
            sb.push_back(vec_run(n));
            tick();
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL midrun n=%0d got=%h want=%h", n, obs, exp_v);
            end
        end
        gps_rst_n = 1'b0;
        sb.push_back(vec_off(1'b0));
        #2;
        exp_v = sb.pop_front();
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL async_reset got=%h want=%h", obs, exp_v);
        end
        tick();
        start_req = 1'b1;
        gps_rst_n = 1'b1;
        for (int k = 1; k < ACK_CYCLE + 20; k++) begin
            sb.push_back(k < ACK_CYCLE ? vec_boot(k) : vec_run(k - ACK_CYCLE + 2));
            tick();
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_restart k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (k == ACK_CYCLE - 1) start_req = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup_run();
        test_stop();
        test_lock_loss();
        test_lock_glitch();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
